fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register.
- Owns the fetch PC and issues requests to instruction memory.
- Buffers returned instructions and presents {PC, instruction, funct3} to decode, including the branch comparator's IFID_Funct3 input.
- Consumes the qualified branch-taken redirect produced in decode, then flushes and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of two, ≥2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; always word-aligned
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after grant
imem_rdata  in  32  response instruction
Hazard_Stall  in  1  decode stall; hold IF/ID
Redirect  in  1  taken branch/jump from decode (IsBranch & BranchCmp)
Redirect_Target  in  32  new fetch PC
IFID_Valid  out  1  IF/ID holds a live instruction
IFID_PC  out  32  PC of the IF/ID instruction
IFID_Instr  out  32  IF/ID instruction word
IFID_Funct3  out  3  IFID_Instr[14:12]

Behaviour:
Reset values (asynchronous on rst_n=0):
- pc_fetch=RESET_PC
- outstanding=0, discard_cnt=0, buffer empty, PC-tag queue empty
- IFID_Valid=0, IFID_PC=0, IFID_Instr=32'h0000_0013 (NOP), IFID_Funct3=0
- imem_req=0 while reset is asserted

Request side:
- imem_req = !Redirect && (outstanding + buf_count < FIFO_DEPTH).
- imem_addr = pc_fetch.
- imem_req & imem_gnt: pc_fetch += 4, 32-bit wrap (32'hFFFF_FFFC → 0); push pc_fetch into the PC-tag queue; outstanding++.
- imem_req=1 without imem_gnt: hold the address. Request stays asserted unless Redirect arrives.

Response side:
- imem_rvalid pops the PC-tag queue and decrements outstanding.
- If discard_cnt>0: drop the response, discard_cnt--.
- Otherwise the {pc, rdata} pair goes to the IF/ID bypass or the buffer.
- imem_rvalid with outstanding==0: ignore and leave all state unchanged (covers a stale response after reset).
- Simultaneous grant and response: outstanding is unchanged; queue push and pop both occur.

IF/ID register, priority Redirect > Hazard_Stall > advance:
- Redirect:
  - IFID_Valid←0; buffer cleared.
  - pc_fetch←{Redirect_Target[31:2],2'b00}.
  - discard_cnt←outstanding minus 1 if a response arrives that cycle. That response is also dropped.
  - A grant is impossible this cycle because imem_req=0.
  - The first request to the target issues the next cycle (1-cycle redirect penalty before request).
- Hazard_Stall (no Redirect):
  - IFID_* hold.
  - Responses enter the buffer; credit rule guarantees no overflow.
- Advance:
  - Buffer non-empty: load head into IF/ID, IFID_Valid←1, pop.
  - Else, kept response this cycle: bypass it straight into IF/ID (0-cycle buffer latency; response at edge N is visible at IF/ID after edge N).
  - Else: IFID_Valid←0 (bubble); IFID_PC/Instr hold their value.
- IFID_Funct3 always equals IFID_Instr[14:12].
- Ordering: buffered entries always drain before the bypass; instructions reach IF/ID strictly in fetch order.

Invariants (assert in bench):
- outstanding + buf_count ≤ FIFO_DEPTH
- discard_cnt ≤ outstanding
- no push to a full buffer, no pop from an empty buffer

Test Plan:
- Reset release, 1-cycle-latency memory, gnt=1: addresses 0,4,8,…; IFID_Valid rises 2 cycles after the first request; IFID_PC=0,4,8 on consecutive cycles.
- Hazard_Stall for 4 cycles while streaming: IF/ID holds PC=8; buffer fills to 2; imem_req drops; on release PCs 12,16,20 follow with no gap or duplicate.
- Redirect to 32'h0000_0103 with 2 responses outstanding: both responses dropped; IFID_Valid=0; next imem_addr=32'h100; first IFID_PC after that is 32'h100.
- Redirect and Hazard_Stall in the same cycle: redirect wins; IF/ID invalid; buffer empty.
- RESET_PC=32'hFFFF_FFF8: fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with 2 outstanding, stale imem_rvalid after release: response ignored; outstanding stays 0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, imem requests, response buffer
// and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        Hazard_Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic        IFID_Valid,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_Instr,
  output logic [2:0]  IFID_Funct3
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_tq_rd;
  logic [AW-1:0] r_tq_wr;
  logic [31:0]   r_bpc  [FIFO_DEPTH];
  logic [31:0]   r_bins [FIFO_DEPTH];
  logic [31:0]   r_tq   [FIFO_DEPTH];
  logic          r_vld;
  logic [31:0]   r_ipc;
  logic [31:0]   r_ins;

  logic [CW:0]   w_sum;
  logic          w_credit;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_drop;
  logic          w_keep;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_byp;
  logic [31:0]   w_rsp_pc;
  logic          w_unused;

  // credits cover both in-flight requests and buffered words
  assign w_sum    = {1'b0, r_out} + {1'b0, r_cnt};
  assign w_credit = w_sum < (CW+1)'(FIFO_DEPTH);
  assign imem_req = rst_n && !Redirect && w_credit;
  assign imem_addr = r_pc;

  assign w_gnt    = imem_req && imem_gnt;
  assign w_rsp    = imem_rvalid && (r_out != '0);
  assign w_drop   = w_rsp && (Redirect || (r_disc != '0));
  assign w_keep   = w_rsp && !w_drop;
  assign w_rsp_pc = r_tq[r_tq_rd];
  assign w_empty  = (r_cnt == '0);

  assign w_pop  = !Redirect && !Hazard_Stall && !w_empty;
  assign w_push = !Redirect && w_keep
                  && (Hazard_Stall || !w_empty);
  assign w_byp  = !Redirect && !Hazard_Stall
                  && w_empty && w_keep;

  assign w_unused = ^Redirect_Target[1:0];

  assign IFID_Valid  = r_vld;
  assign IFID_PC     = r_ipc;
  assign IFID_Instr  = r_ins;
  assign IFID_Funct3 = r_ins[14:12];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bpc[r_wr]  <= w_rsp_pc;
      r_bins[r_wr] <= imem_rdata;
    end
    if (w_gnt) r_tq[r_tq_wr] <= r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_disc  <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_tq_rd <= '0;
      r_tq_wr <= '0;
      r_vld   <= 1'b0;
      r_ipc   <= '0;
      r_ins   <= 32'h0000_0013;
    end else begin
      if (w_gnt) begin
        r_pc    <= r_pc + 32'd4;
        r_tq_wr <= r_tq_wr + AW'(1);
      end
      if (w_rsp) r_tq_rd <= r_tq_rd + AW'(1);
      r_out <= r_out + CW'(w_gnt) - CW'(w_rsp);
      if (Redirect) begin
        // in-flight words belong to the old path
        r_pc   <= {Redirect_Target[31:2], 2'b00};
        r_disc <= r_out - CW'(w_rsp);
        r_cnt  <= '0;
        r_rd   <= '0;
        r_wr   <= '0;
        r_vld  <= 1'b0;
      end else begin
        if (w_rsp && (r_disc != '0))
          r_disc <= r_disc - CW'(1);
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (!Hazard_Stall) begin
          unique case (1'b1)
            w_pop: begin
              r_vld <= 1'b1;
              r_ipc <= r_bpc[r_rd];
              r_ins <= r_bins[r_rd];
            end
            w_byp: begin
              r_vld <= 1'b1;
              r_ipc <= w_rsp_pc;
              r_ins <= imem_rdata;
            end
            default: r_vld <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule
